// File: rtl/systolic_array_ctrl_if.sv
// Handshake and data bundle between the operand buffers, the systolic array
// and the result writeback path.
interface systolic_array_ctrl_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 9,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
);
    logic                      start;
    logic                      acc_mode;
    logic [K_W-1:0]            k_len;
    logic [ROWS*A_W-1:0]       a_data;
    logic [COLS*B_W-1:0]       b_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      busy;
    logic                      done;
    logic                      c_valid;
    logic [ROWS*COLS*ACC_W-1:0] c_bus;

    modport master (
        output start, acc_mode, k_len, a_data, b_data, in_valid,
        input  in_ready, busy, done, c_valid, c_bus
    );
    modport slave (
        input  start, acc_mode, k_len, a_data, b_data, in_valid,
        output in_ready, busy, done, c_valid, c_bus
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Output-stationary ROWS x COLS systolic matmul array with its tile sequencer:
// A flows right, B flows down, each PE keeps one C element.

module systolic_pe #(
    parameter int A_W   = 8,
    parameter int B_W   = 9,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_ops,
    input  logic             clr_acc,
    input  logic             adv,
    input  logic [A_W-1:0]   a_in,
    input  logic [B_W-1:0]   b_in,
    output logic [A_W-1:0]   a_out,
    output logic [B_W-1:0]   b_out,
    output logic [ACC_W-1:0] acc
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] prod;
    logic [ACC_W-1:0]      prod_ext;

    // Size casts sign-extend the signed operands; the final cast either
    // sign-extends or truncates so the sum wraps modulo 2^ACC_W.
    assign prod     = P_W'($signed(a_in)) * P_W'($signed(b_in));
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            if (clr_ops) begin
                a_out <= '0;
                b_out <= '0;
            end else if (adv) begin
                a_out <= a_in;
                b_out <= b_in;
            end
            if (clr_acc)  acc <= '0;
            else if (adv) acc <= acc + prod_ext;
        end
    end
endmodule

module systolic_skew #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (D == 0) begin : g_thru
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, clr, adv};
        assign q = d;
    end else begin : g_dly
        logic [D-1:0][W-1:0] sr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (clr) begin
                sr <= '0;
            end else if (adv) begin
                sr[0] <= d;
                for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[D-1];
    end
endmodule

module systolic_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int A_W   = 8,
    parameter int B_W   = 9,
    parameter int ACC_W = 32,
    parameter int K_W   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    systolic_array_ctrl_if.slave io
);
    localparam int FL  = ROWS + COLS - 2;
    localparam int F_W = $clog2(FL + 1) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_lat, beat_cnt;
    logic [F_W-1:0] fl_cnt;
    logic           c_valid_q;
    logic           take_start, streaming, beat, adv, last_beat, last_flush;

    assign take_start = (state_q == IDLE) && io.start;
    assign streaming  = (state_q == STREAM);
    assign beat       = streaming && io.in_valid;
    // A stalled STREAM cycle freezes everything; FLUSH always advances.
    assign adv        = beat || (state_q == FLUSH);
    assign last_beat  = (beat_cnt == k_lat - K_W'(1));
    assign last_flush = (fl_cnt == F_W'(FL - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = (io.k_len == '0) ? DONE : STREAM;
            STREAM:  if (beat && last_beat) state_d = (FL == 0) ? DONE : FLUSH;
            FLUSH:   if (last_flush) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            fl_cnt    <= '0;
            c_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_start) k_lat <= io.k_len;
            if (state_q == IDLE) beat_cnt <= '0;
            else if (beat)       beat_cnt <= beat_cnt + K_W'(1);
            if (state_q != FLUSH) fl_cnt <= '0;
            else                  fl_cnt <= fl_cnt + F_W'(1);
            if (state_d == DONE)  c_valid_q <= 1'b1;
            else if (take_start)  c_valid_q <= 1'b0;
        end
    end

    assign io.in_ready = streaming;
    assign io.busy     = (state_q != IDLE);
    assign io.done     = (state_q == DONE);
    assign io.c_valid  = c_valid_q;

    logic [ROWS-1:0][COLS:0][A_W-1:0]   a_h;
    logic [ROWS:0][COLS-1:0][B_W-1:0]   b_v;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] acc;
    logic [ROWS*COLS*ACC_W-1:0]         c_flat;
    logic [ROWS-1:0][A_W-1:0]           unused_a_tail;
    logic [COLS-1:0][B_W-1:0]           unused_b_tail;

    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        systolic_skew #(.W(A_W), .D(r)) u_skew (
            .clk(clk), .rst_n(rst_n), .clr(take_start), .adv(adv),
            .d(streaming ? io.a_data[(ROWS-1-r)*A_W +: A_W] : '0),
            .q(a_h[r][0])
        );
        assign unused_a_tail[r] = a_h[r][COLS];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        systolic_skew #(.W(B_W), .D(c)) u_skew (
            .clk(clk), .rst_n(rst_n), .clr(take_start), .adv(adv),
            .d(streaming ? io.b_data[(COLS-1-c)*B_W +: B_W] : '0),
            .q(b_v[0][c])
        );
    end
    assign unused_b_tail = b_v[ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            systolic_pe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) u_pe (
                .clk(clk), .rst_n(rst_n),
                .clr_ops(take_start), .clr_acc(take_start && !io.acc_mode),
                .adv(adv),
                .a_in(a_h[r][c]), .b_in(b_v[r][c]),
                .a_out(a_h[r][c+1]), .b_out(b_v[r+1][c]),
                .acc(acc[r][c])
            );
            assign c_flat[(r*COLS+c)*ACC_W +: ACC_W] = acc[r][c];
        end
    end

    assign io.c_bus = c_flat;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: a 4x4/32-bit array and a 2x3/16-bit
// array, with hand-computed results and done latencies.
module tb_systolic_array_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_ctrl_if #(.ROWS(4), .COLS(4), .A_W(8), .B_W(9), .ACC_W(32), .K_W(16)) s ();
    systolic_array_ctrl_if #(.ROWS(2), .COLS(3), .A_W(8), .B_W(9), .ACC_W(16), .K_W(16)) m ();

    systolic_array_ctrl #(.ROWS(4), .COLS(4), .A_W(8), .B_W(9), .ACC_W(32), .K_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .io(s.slave)
    );
    systolic_array_ctrl #(.ROWS(2), .COLS(3), .A_W(8), .B_W(9), .ACC_W(16), .K_W(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .io(m.slave)
    );

    logic [31:0] a_v [8];
    logic [35:0] b_v [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [63:0] c4(input int i, input int j);
        logic signed [31:0] v;
        v = s.c_bus[(i*4+j)*32 +: 32];
        return 64'(v);
    endfunction

    function automatic logic [63:0] c23(input int i, input int j);
        logic [15:0] v;
        v = m.c_bus[(i*3+j)*16 +: 16];
        return 64'(v);
    endfunction

    task automatic fill_const(input logic [7:0] a, input logic [8:0] b);
        for (int k = 0; k < 8; k++) begin
            a_v[k] = {4{a}};
            b_v[k] = {4{b}};
        end
    endtask

    // A = identity, B[k][j] = 4k+j+1
    task automatic fill_ident();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                a_v[k][(3-i)*8 +: 8] = (i == k) ? 8'd1 : 8'd0;
                b_v[k][(3-i)*9 +: 9] = 9'(4*k + i + 1);
            end
        end
    endtask

    // Runs one tile on the 4x4 array; returns done latency from the start
    // cycle and the number of cycles in_ready was seen high.
    task automatic run4(input int k, input bit accm, input int stall_at, input int stall_n,
                        input bit pulse_flush, output int lat, output int rdy);
        int bi, st, t0, n;
        bit pulsed;
        @(negedge clk);
        s.start = 1'b1; s.acc_mode = accm; s.k_len = 16'(k); t0 = cyc;
        bi = 0; st = 0; n = 0; lat = -1; rdy = 0; pulsed = 1'b0;
        @(negedge clk);
        while (lat < 0 && n < 200) begin
            s.start = 1'b0;
            if (s.done) lat = cyc - t0;
            if (s.in_ready) begin
                rdy++;
                if (bi == stall_at && st < stall_n) begin
                    s.in_valid = 1'b0; st++;
                end else if (bi < k) begin
                    s.in_valid = 1'b1; s.a_data = a_v[bi]; s.b_data = b_v[bi]; bi++;
                end else s.in_valid = 1'b0;
            end else s.in_valid = 1'b0;
            if (pulse_flush && !pulsed && s.busy && !s.in_ready && !s.done) begin
                s.start = 1'b1; s.acc_mode = 1'b0; pulsed = 1'b1;
            end
            if (lat < 0) @(negedge clk);
            n++;
        end
        s.start = 1'b0; s.in_valid = 1'b0;
    endtask

    task automatic check_ident(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), c4(i, j), 64'(4*i + j + 1));
    endtask

    task automatic check_all4(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), c4(i, j), exp);
    endtask

    initial begin
        int lat, rdy, t0, n;
        s.start = 0; s.acc_mode = 0; s.k_len = '0; s.a_data = '0; s.b_data = '0; s.in_valid = 0;
        m.start = 0; m.acc_mode = 0; m.k_len = '0; m.a_data = '0; m.b_data = '0; m.in_valid = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", s.in_ready, 0);
        check("rst_busy", s.busy, 0);
        check("rst_done", s.done, 0);
        check("rst_cvalid", s.c_valid, 0);
        check("rst_cbus", 64'(|s.c_bus), 0);
        rst_n = 1'b1;

        // identity A
        fill_ident();
        run4(4, 1'b0, -1, 0, 1'b0, lat, rdy);
        check("id_lat", lat, 11);
        check("id_rdy", rdy, 4);
        check("id_cvalid", s.c_valid, 1);
        check_ident("id");
        repeat (3) @(negedge clk);
        check("id_cvalid_hold", s.c_valid, 1);
        check("id_hold_c33", c4(3, 3), 16);

        // 3 stall cycles between beats 2 and 3
        run4(4, 1'b0, 2, 3, 1'b0, lat, rdy);
        check("stall_lat", lat, 14);
        check("stall_rdy", rdy, 7);
        check_ident("stall");

        // signed extremes
        fill_const(8'h80, 9'h100);
        run4(3, 1'b0, -1, 0, 1'b0, lat, rdy);
        check("neg_lat", lat, 10);
        check_all4("negneg", 64'(98304));
        fill_const(8'h7f, 9'h100);
        run4(3, 1'b0, -1, 0, 1'b0, lat, rdy);
        check_all4("posneg", -64'sd97536);

        // accumulate across tiles
        fill_const(8'h01, 9'h001);
        run4(2, 1'b0, -1, 0, 1'b0, lat, rdy);
        check_all4("acc0", 64'(2));
        run4(2, 1'b1, -1, 0, 1'b0, lat, rdy);
        check_all4("acc1", 64'(4));
        run4(0, 1'b0, -1, 0, 1'b0, lat, rdy);
        check("k0_lat", lat, 1);
        check_all4("k0", 64'(0));

        // start during FLUSH must be ignored
        fill_ident();
        run4(4, 1'b0, -1, 0, 1'b1, lat, rdy);
        check("fstart_lat", lat, 11);
        check_ident("fstart");
        @(negedge clk);
        check("fstart_idle", s.busy, 0);

        // async reset mid-STREAM
        @(negedge clk);
        s.start = 1'b1; s.acc_mode = 1'b0; s.k_len = 16'd4;
        @(negedge clk);
        s.start = 1'b0; s.in_valid = 1'b1; s.a_data = a_v[0]; s.b_data = b_v[0];
        @(negedge clk);
        s.a_data = a_v[1]; s.b_data = b_v[1];
        @(negedge clk);
        s.in_valid = 1'b0;
        check("pre_rst_busy", s.busy, 1);
        check("pre_rst_c00", c4(0, 0), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", s.busy, 0);
        check("mid_rst_ready", s.in_ready, 0);
        check("mid_rst_done", s.done, 0);
        check("mid_rst_cvalid", s.c_valid, 0);
        check("mid_rst_cbus", 64'(|s.c_bus), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2x3, 16-bit accumulators: 3*127*255 = 97155 wraps to 31619
        @(negedge clk);
        m.start = 1'b1; m.acc_mode = 1'b0; m.k_len = 16'd3; t0 = cyc;
        m.a_data = {2{8'd127}}; m.b_data = {3{9'd255}};
        lat = -1; n = 0;
        @(negedge clk);
        m.start = 1'b0;
        while (lat < 0 && n < 100) begin
            if (m.done) lat = cyc - t0;
            m.in_valid = m.in_ready;
            if (lat < 0) @(negedge clk);
            n++;
        end
        m.in_valid = 1'b0;
        check("s23_lat", lat, 7);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("s23_c%0d%0d", i, j), c23(i, j), 64'(31619));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
